// File: rtl/cgra4ml_axi2ram.sv
// cgra4ml_axi2ram: AXI4-Lite configured engine that adds pixel and weight RAM words bytewise into
// an output RAM. Define WEIGHTS_CHECKSUM_EN to build the weights checksum register.
module cgra4ml_axi2ram #(
    parameter int ADDR_WIDTH         = 40,
    parameter int DATA_WR_WIDTH      = 32,
    parameter int DATA_RD_WIDTH      = 32,
    parameter int STRB_WIDTH         = 4,
    parameter int C_S_AXI_DATA_WIDTH = 128,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int LSB                = $clog2(C_S_AXI_DATA_WIDTH) - 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [ADDR_WIDTH-1:0]                  s_axil_awaddr,
    input  logic [2:0]                             s_axil_awprot,
    input  logic                                   s_axil_awvalid,
    output logic                                   s_axil_awready,
    input  logic [DATA_WR_WIDTH-1:0]               s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]                  s_axil_wstrb,
    input  logic                                   s_axil_wvalid,
    output logic                                   s_axil_wready,
    output logic [1:0]                             s_axil_bresp,
    output logic                                   s_axil_bvalid,
    input  logic                                   s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]                  s_axil_araddr,
    input  logic [2:0]                             s_axil_arprot,
    input  logic                                   s_axil_arvalid,
    output logic                                   s_axil_arready,
    output logic [DATA_RD_WIDTH-1:0]               s_axil_rdata,
    output logic [1:0]                             s_axil_rresp,
    output logic                                   s_axil_rvalid,
    input  logic                                   s_axil_rready,
    output logic                                   o_rd_pixel,
    output logic [C_S_AXI_ADDR_WIDTH-LSB-1:0]      o_raddr_pixel,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          i_rdata_pixel,
    output logic                                   o_rd_weights,
    output logic [C_S_AXI_ADDR_WIDTH-LSB-1:0]      o_raddr_weights,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          i_rdata_weights,
    output logic                                   o_we_output,
    output logic [C_S_AXI_ADDR_WIDTH-LSB-1:0]      o_waddr_output,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          o_wdata_output,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]        o_wstrb_output
);

    localparam int AW = C_S_AXI_ADDR_WIDTH - LSB;
    localparam int NB = C_S_AXI_DATA_WIDTH / 8;
    localparam int NL = C_S_AXI_DATA_WIDTH / 32;

    typedef enum logic [1:0] {StIdle, StRd, StWr} state_t;

    state_t                   state_q;
    logic [DATA_WR_WIDTH-1:0] pixel_base_q, weights_base_q, output_base_q, length_q;
    logic                     done_q;
    logic [AW-1:0]            pix_lat_q, wt_lat_q, out_lat_q;
    logic [DATA_WR_WIDTH-1:0] len_lat_q, idx_q;
    logic [AW-1:0]            idx_next;

    logic                     wr_hs, rd_hs, start_req;
    logic [7:0]               wr_addr;
    logic [DATA_RD_WIDTH-1:0] rd_mux;

    logic unused_bits;
    assign unused_bits = ^{s_axil_awprot, s_axil_arprot,
                           s_axil_awaddr[ADDR_WIDTH-1:8], s_axil_araddr[ADDR_WIDTH-1:8]};

    assign s_axil_bresp = 2'b00;
    assign s_axil_rresp = 2'b00;

    assign wr_hs     = s_axil_awready && s_axil_awvalid && s_axil_wvalid;
    assign rd_hs     = s_axil_arready && s_axil_arvalid;
    assign wr_addr   = s_axil_awaddr[7:0];
    assign start_req = wr_hs && (wr_addr == 8'h00) && s_axil_wstrb[0] && s_axil_wdata[0];
    assign idx_next  = AW'(idx_q + 1);

    function automatic logic [DATA_WR_WIDTH-1:0] apply_strb(
        input logic [DATA_WR_WIDTH-1:0] old_v,
        input logic [DATA_WR_WIDTH-1:0] new_v,
        input logic [STRB_WIDTH-1:0]    strb
    );
        logic [DATA_WR_WIDTH-1:0] r;
        r = old_v;
        for (int b = 0; b < STRB_WIDTH; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

`ifdef WEIGHTS_CHECKSUM_EN
    logic [31:0] checksum_q, lanes_xor;

    always_comb begin
        lanes_xor = '0;
        for (int l = 0; l < NL; l++) lanes_xor = lanes_xor ^ i_rdata_weights[32*l +: 32];
    end

    // The weights word consumed in a WR cycle is the one presented on the read port then.
    always_ff @(posedge clk) begin
        if (rst)                                checksum_q <= '0;
        else if (start_req && state_q == StIdle) checksum_q <= '0;
        else if (state_q == StWr)               checksum_q <= checksum_q ^ lanes_xor;
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (s_axil_araddr[7:0])
            8'h04:   rd_mux = DATA_RD_WIDTH'({done_q, state_q != StIdle});
            8'h08:   rd_mux = DATA_RD_WIDTH'(pixel_base_q);
            8'h0C:   rd_mux = DATA_RD_WIDTH'(weights_base_q);
            8'h10:   rd_mux = DATA_RD_WIDTH'(output_base_q);
            8'h14:   rd_mux = DATA_RD_WIDTH'(length_q);
`ifdef WEIGHTS_CHECKSUM_EN
            8'h18:   rd_mux = DATA_RD_WIDTH'(checksum_q);
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rdata   <= '0;
            pixel_base_q   <= '0;
            weights_base_q <= '0;
            output_base_q  <= '0;
            length_q       <= '0;
        end else begin
            s_axil_awready <= s_axil_awvalid && s_axil_wvalid && !s_axil_bvalid && !s_axil_awready;
            s_axil_wready  <= s_axil_awvalid && s_axil_wvalid && !s_axil_bvalid && !s_axil_awready;
            if (wr_hs)              s_axil_bvalid <= 1'b1;
            else if (s_axil_bready) s_axil_bvalid <= 1'b0;
            if (wr_hs) begin
                case (wr_addr)
                    8'h08:   pixel_base_q   <= apply_strb(pixel_base_q, s_axil_wdata, s_axil_wstrb);
                    8'h0C:   weights_base_q <= apply_strb(weights_base_q, s_axil_wdata, s_axil_wstrb);
                    8'h10:   output_base_q  <= apply_strb(output_base_q, s_axil_wdata, s_axil_wstrb);
                    8'h14:   length_q       <= apply_strb(length_q, s_axil_wdata, s_axil_wstrb);
                    default: ;
                endcase
            end
            s_axil_arready <= s_axil_arvalid && !s_axil_rvalid && !s_axil_arready;
            if (rd_hs) begin
                s_axil_rvalid <= 1'b1;
                s_axil_rdata  <= rd_mux;
            end else if (s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            done_q          <= 1'b0;
            pix_lat_q       <= '0;
            wt_lat_q        <= '0;
            out_lat_q       <= '0;
            len_lat_q       <= '0;
            idx_q           <= '0;
            o_rd_pixel      <= 1'b0;
            o_rd_weights    <= 1'b0;
            o_raddr_pixel   <= '0;
            o_raddr_weights <= '0;
            o_we_output     <= 1'b0;
            o_waddr_output  <= '0;
            o_wstrb_output  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_req) begin
                        if (length_q == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            done_q          <= 1'b0;
                            state_q         <= StRd;
                            pix_lat_q       <= pixel_base_q[AW-1:0];
                            wt_lat_q        <= weights_base_q[AW-1:0];
                            out_lat_q       <= output_base_q[AW-1:0];
                            len_lat_q       <= length_q;
                            idx_q           <= '0;
                            o_rd_pixel      <= 1'b1;
                            o_rd_weights    <= 1'b1;
                            o_raddr_pixel   <= pixel_base_q[AW-1:0];
                            o_raddr_weights <= weights_base_q[AW-1:0];
                        end
                    end
                end
                StRd: begin
                    state_q        <= StWr;
                    o_rd_pixel     <= 1'b0;
                    o_rd_weights   <= 1'b0;
                    o_we_output    <= 1'b1;
                    o_waddr_output <= out_lat_q + idx_q[AW-1:0];
                    o_wstrb_output <= '1;
                end
                StWr: begin
                    o_we_output    <= 1'b0;
                    o_wstrb_output <= '0;
                    if (idx_q == len_lat_q - 1) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end else begin
                        state_q         <= StRd;
                        idx_q           <= idx_q + 1;
                        o_rd_pixel      <= 1'b1;
                        o_rd_weights    <= 1'b1;
                        o_raddr_pixel   <= pix_lat_q + idx_next;
                        o_raddr_weights <= wt_lat_q + idx_next;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Read data arrives during the WR cycle, so the sum is formed straight from the ports.
    always_comb begin
        o_wdata_output = '0;
        for (int b = 0; b < NB; b++) begin
            o_wdata_output[8*b +: 8] = i_rdata_pixel[8*b +: 8] + i_rdata_weights[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_cgra4ml_axi2ram.sv
// Scoreboard bench for cgra4ml_axi2ram: random RAM contents, a behavioural model of each run, and a
// negedge monitor that checks every output write and every AXI-Lite response.
module tb_cgra4ml_axi2ram;

    localparam int DW = 128;
    localparam int AW = 28;
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [39:0]   awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          rd_pixel, rd_weights, we_output;
    logic [AW-1:0] raddr_pixel, raddr_weights, waddr_output;
    logic [DW-1:0] rdata_pixel = '0, rdata_weights = '0, wdata_output;
    logic [NB-1:0] wstrb_output;

    always #5 clk = ~clk;

    cgra4ml_axi2ram dut (
        .clk             (clk),
        .rst             (rst),
        .s_axil_awaddr   (awaddr),
        .s_axil_awprot   (awprot),
        .s_axil_awvalid  (awvalid),
        .s_axil_awready  (awready),
        .s_axil_wdata    (wdata),
        .s_axil_wstrb    (wstrb),
        .s_axil_wvalid   (wvalid),
        .s_axil_wready   (wready),
        .s_axil_bresp    (bresp),
        .s_axil_bvalid   (bvalid),
        .s_axil_bready   (bready),
        .s_axil_araddr   (araddr),
        .s_axil_arprot   (arprot),
        .s_axil_arvalid  (arvalid),
        .s_axil_arready  (arready),
        .s_axil_rdata    (rdata),
        .s_axil_rresp    (rresp),
        .s_axil_rvalid   (rvalid),
        .s_axil_rready   (rready),
        .o_rd_pixel      (rd_pixel),
        .o_raddr_pixel   (raddr_pixel),
        .i_rdata_pixel   (rdata_pixel),
        .o_rd_weights    (rd_weights),
        .o_raddr_weights (raddr_weights),
        .i_rdata_weights (rdata_weights),
        .o_we_output     (we_output),
        .o_waddr_output  (waddr_output),
        .o_wdata_output  (wdata_output),
        .o_wstrb_output  (wstrb_output)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            off;
    } wr_t;

    wr_t           exp_wr[$];
    logic [31:0]   exp_rd[$];
    logic [DW-1:0] pix_mem[logic [AW-1:0]];
    logic [DW-1:0] wt_mem[logic [AW-1:0]];
    logic [31:0]   ck_model;
    int vectors = 0, miscompares = 0;
    int cyc = 0, start_cyc = 0, we_count = 0, rd_count = 0, rd_done = 0, b_done = 0, run_w0 = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix_word(input logic [AW-1:0] a);
        if (!pix_mem.exists(a)) pix_mem[a] = {$urandom, $urandom, $urandom, $urandom};
        return pix_mem[a];
    endfunction

    function automatic logic [DW-1:0] wt_word(input logic [AW-1:0] a);
        if (!wt_mem.exists(a)) wt_mem[a] = {$urandom, $urandom, $urandom, $urandom};
        return wt_mem[a];
    endfunction

    function automatic logic [DW-1:0] byte_sum(input logic [DW-1:0] p, input logic [DW-1:0] w);
        logic [DW-1:0] r;
        for (int b = 0; b < NB; b++) begin
            int s;
            s = int'(p[8*b +: 8]) + int'(w[8*b +: 8]);
            r[8*b +: 8] = 8'(s % 256);
        end
        return r;
    endfunction

    // Host memory model: one-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_pixel)   rdata_pixel   <= pix_word(raddr_pixel);
        if (rd_weights) rdata_weights <= wt_word(raddr_weights);
    end

    always @(negedge clk) begin : monitor
        wr_t e;
        if (!rst) begin
            if (rd_pixel) rd_count++;
            if (we_output) begin
                we_count++;
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", DW'(waddr_output), '1);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", DW'(waddr_output), DW'(e.addr));
                    check("wr_data", wdata_output, e.data);
                    check("wr_strb", DW'(wstrb_output), DW'({NB{1'b1}}));
                    check("wr_cycle", DW'(cyc - start_cyc), DW'(e.off));
                end
            end
            if (rvalid && rready) begin
                rd_done++;
                if (exp_rd.size() == 0) check("rd_unexpected", DW'(rdata), '1);
                else check("rd_data", DW'(rdata), DW'(exp_rd.pop_front()));
                check("rd_resp", DW'(rresp), '0);
            end
            if (bvalid && bready) begin
                b_done++;
                check("wr_resp", DW'(bresp), '0);
            end
        end
    end

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit arm);
        int n, b0;
        b0 = b_done;
        @(negedge clk);
        awaddr = {32'h0, a}; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (!awready) check("aw_timeout", '0, 1);
        else if (arm) start_cyc = cyc;
        @(posedge clk);
        #1 awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (b_done == b0 && n < 50) begin @(negedge clk); n++; end
        if (b_done == b0) check("b_timeout", '0, 1);
    endtask

    task automatic axi_read(input logic [7:0] a, input logic [31:0] exp);
        int n, r0;
        r0 = rd_done;
        exp_rd.push_back(exp);
        @(negedge clk);
        araddr = {32'h0, a}; arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (!arready) begin
            check("ar_timeout", '0, 1);
            void'(exp_rd.pop_back());
        end
        @(posedge clk);
        #1 arvalid = 1'b0;
        n = 0;
        while (rd_done == r0 && n < 50) begin @(negedge clk); n++; end
        if (rd_done == r0) check("r_timeout", '0, 1);
    endtask

    task automatic setup(input logic [AW-1:0] pb, input logic [AW-1:0] wb,
                         input logic [AW-1:0] ob, input int len);
        logic [DW-1:0] w;
        axi_write(8'h08, 32'(pb), 4'hF, 1'b0);
        axi_write(8'h0C, 32'(wb), 4'hF, 1'b0);
        axi_write(8'h10, 32'(ob), 4'hF, 1'b0);
        axi_write(8'h14, 32'(len), 4'hF, 1'b0);
        ck_model = '0;
        for (int i = 0; i < len; i++) begin
            wr_t e;
            w = wt_word(wb + AW'(i));
            e.addr = ob + AW'(i);
            e.data = byte_sum(pix_word(pb + AW'(i)), w);
            e.off  = 2 * (i + 1);
            exp_wr.push_back(e);
            for (int l = 0; l < DW / 32; l++) ck_model = ck_model ^ w[32*l +: 32];
        end
        run_w0 = we_count;
        axi_write(8'h00, 32'h1, 4'h1, 1'b1);
    endtask

    task automatic finish_run(input int len);
        int n;
        n = 0;
        while (exp_wr.size() != 0 && n < 2 * len + 20) begin @(negedge clk); n++; end
        if (exp_wr.size() != 0) begin
            check("run_timeout", DW'(exp_wr.size()), '0);
            exp_wr.delete();
        end
        @(negedge clk);
        check("wr_count", DW'(we_count - run_w0), DW'(len));
        axi_read(8'h04, 32'h2);
`ifdef WEIGHTS_CHECKSUM_EN
        axi_read(8'h18, ck_model);
`else
        axi_read(8'h18, 32'h0);
`endif
    endtask

    task automatic run(input logic [AW-1:0] pb, input logic [AW-1:0] wb,
                       input logic [AW-1:0] ob, input int len);
        setup(pb, wb, ob, len);
        finish_run(len);
    endtask

    initial begin
        logic [AW-1:0] pb, wb, ob;
        int len, r0, w0;
        rst = 1'b1;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", DW'({rd_pixel, rd_weights, we_output, wstrb_output}), '0);
        check("rst_axi", DW'({awready, wready, arready, bvalid, rvalid}), '0);
        rst = 1'b0;
        axi_read(8'h04, 32'h0);

        // LENGTH=0 start: DONE only, no memory traffic.
        r0 = rd_count; w0 = we_count;
        axi_write(8'h00, 32'h1, 4'h1, 1'b1);
        repeat (4) @(negedge clk);
        check("len0_traffic", DW'({rd_count - r0, we_count - w0}), '0);
        axi_read(8'h04, 32'h2);

        axi_write(8'h08, 32'h12345678, 4'b0011, 1'b0);
        axi_read(8'h08, 32'h00005678);
        axi_read(8'h40, 32'h0);
        axi_read(8'h00, 32'h0);

        for (int i = 0; i < 4; i++) begin
            pix_mem[AW'(28'h10 + i)] = {NB{8'h01}};
            wt_mem[AW'(28'h20 + i)]  = {NB{8'hFF}};
        end
        run(28'h10, 28'h20, 28'h30, 4);

        wt_mem[28'h100] = {32'h8, 32'h4, 32'h2, 32'h1};
        wt_mem[28'h101] = {32'h8, 32'h4, 32'h2, 32'h1};
        run(28'h200, 28'h100, 28'h300, 2);

        run(28'hFFFFFFE, 28'hFFFFFFD, 28'hFFFFFFF, 5);

        for (int r = 0; r < 6; r++) begin
            pb = AW'($urandom); wb = AW'($urandom); ob = AW'($urandom);
            len = int'($urandom_range(1, 8));
            run(pb, wb, ob, len);
        end

        // Rewrites and a second START while busy must not disturb the latched run.
        setup(28'h500, 28'h600, 28'h700, 6);
        axi_write(8'h14, 32'h2, 4'hF, 1'b0);
        axi_write(8'h08, 32'h999, 4'hF, 1'b0);
        axi_write(8'h00, 32'h1, 4'h1, 1'b0);
        finish_run(6);
        axi_read(8'h14, 32'h2);

        // Reset in the middle of a run.
        setup(28'h800, 28'h900, 28'hA00, 8);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        exp_wr.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_strobes", DW'({rd_pixel, rd_weights, we_output}), '0);
        @(negedge clk);
        rst = 1'b0;
        r0 = rd_count; w0 = we_count;
        repeat (6) @(negedge clk);
        check("post_rst_traffic", DW'({rd_count - r0, we_count - w0}), '0);
        axi_read(8'h04, 32'h0);
        axi_read(8'h14, 32'h0);
        axi_read(8'h18, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cgra4ml_axi2ram.md
# cgra4ml_axi2ram

Memory-mapped streaming engine used as the system-level DUT of the CGRA4ML simulation environment. Software configures it over an AXI4-Lite slave; on start it reads pixel and weight words from two RAM-style read ports, combines them bytewise and writes results through a RAM-style write port. The host memory model sits behind the three RAM ports.

## Interface
- ADDR_WIDTH, 40, AXI-Lite address width
- DATA_WR_WIDTH / DATA_RD_WIDTH, 32, AXI-Lite data width
- STRB_WIDTH, 4, AXI-Lite write strobe width
- C_S_AXI_DATA_WIDTH, 128, RAM port data width (power of two, ≥32)
- C_S_AXI_ADDR_WIDTH, 32, RAM byte-address width
- LSB, $clog2(C_S_AXI_DATA_WIDTH)-3, byte-to-word shift; RAM word address width AW = C_S_AXI_ADDR_WIDTH-LSB

- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- s_axil_aw{addr,prot,valid}/awready, w{data,strb,valid}/wready, b{resp,valid}/bready, ar{addr,prot,valid}/arready, r{data,resp,valid}/rready — standard AXI4-Lite slave, widths per parameters; prot ignored
- o_rd_pixel  out  1  pixel read strobe
- o_raddr_pixel  out  AW  pixel word address
- i_rdata_pixel  in  C_S_AXI_DATA_WIDTH  pixel data, valid cycle after o_rd_pixel
- o_rd_weights / o_raddr_weights / i_rdata_weights — same for weights
- o_we_output  out  1  output write strobe
- o_waddr_output  out  AW  output word address
- o_wdata_output  out  C_S_AXI_DATA_WIDTH  output data
- o_wstrb_output  out  C_S_AXI_DATA_WIDTH/8  byte enables

## Operation
- Registers (byte addr, addr[7:0] decoded, upper bits ignored): 0x00 CTRL (bit0 START, write-1 pulse, reads 0); 0x04 STATUS (RO; bit0 BUSY, bit1 DONE sticky, cleared by START); 0x08 PIXEL_BASE; 0x0C WEIGHTS_BASE; 0x10 OUTPUT_BASE (word addresses, low AW bits used); 0x14 LENGTH (words); 0x18 CHECKSUM (RO, see Configuration).
- Writes honour wstrb per byte. Unmapped/RO writes ignored; unmapped reads return 0. bresp/rresp always OKAY (2'b00).
- FSM: IDLE → (START, LENGTH≠0) RD → WR → RD … ; after WR of index LENGTH-1 → IDLE, DONE=1. START with LENGTH=0: DONE=1 next cycle, no memory access. START while BUSY ignored.
- RD: o_rd_pixel=o_rd_weights=1, addresses PIXEL_BASE+i, WEIGHTS_BASE+i.
- WR: o_we_output=1, o_waddr_output=OUTPUT_BASE+i, o_wdata_output = bytewise modulo-256 sum of i_rdata_pixel and i_rdata_weights (combinational from inputs), o_wstrb_output all ones; i increments.
- Address arithmetic modulo 2^AW (wrap-around, no error). Base/LENGTH registers may be rewritten while BUSY; engine uses values latched at START.

## Timing
- Reset: all outputs 0, awready/wready/arready 0, bvalid/rvalid 0, all registers 0, FSM IDLE.
- AXI write: awready and wready asserted together for one cycle when awvalid&&wvalid&&!bvalid; register updates at that edge; bvalid next cycle, held until bready.
- AXI read: arready one cycle when arvalid&&!rvalid; rvalid+rdata next cycle, held stable until rready.
- BUSY rises the cycle after START write accepted; first RD in that same cycle.
- Throughput 2 cycles/word; LENGTH=N completes in 2N cycles; BUSY falls and DONE rises the cycle after last WR.
- Reset mid-operation aborts immediately; no further strobes after reset edge.

## Configuration
- WEIGHTS_CHECKSUM_EN defined: CHECKSUM = XOR of all 32-bit lanes of every weights word consumed since last START (cleared by START, updated in each WR cycle).
- Undefined: CHECKSUM reads 0, no checksum logic.

## Test plan
- Reset: hold rst 2 cycles → all strobes 0, STATUS reads 0x0.
- Register R/W: write 0x12345678 to 0x08 with wstrb=4'b0011 → readback 0x00005678; read 0x40 → 0, OKAY.
- Run LENGTH=4, bases 0x10/0x20/0x30, pixel bytes 0x01, weights bytes 0xFF → output words at 0x30..0x33 all bytes 0x00, DONE after 8 cycles.
- LENGTH=0 START → DONE=1, no o_rd/o_we pulses.
- START during BUSY → ignored, exactly LENGTH writes; reset mid-run → strobes stop, STATUS 0.
- With WEIGHTS_CHECKSUM_EN, two weight words of lanes 0x1,0x2,0x4,0x8 → CHECKSUM 0x0; without macro → 0.
